tap_delay_line_ctrl: RTL

Parametrised tapped delay line with built-in per-tap enable generation, the next generation of the enable-gated register bank. It holds the LENGTH-deep input regressor vector of the spline adaptive filter. Its modes are shift, parallel load, flush and hold. A per-tap freeze mask, a warm-up fill counter and a registered update strobe let the downstream filter datapath tell when the vector is valid.

---
 rtl/tap_delay_line_ctrl_pkg.sv | 17 +
 rtl/tap_delay_line_ctrl_if.sv | 32 +++
 rtl/tap_delay_line_ctrl_delay.sv | 27 ++
 rtl/tap_delay_line_ctrl.sv | 104 ++++++++++
 4 files changed

// File: rtl/tap_delay_line_ctrl_pkg.sv
// Shared mode encodings and fill-counter sizing for the tapped delay line.
// Imported by the interface, the tap register and the top level.
package tap_delay_line_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_SHIFT = 2'b00,
    MODE_LOAD  = 2'b01,
    MODE_FLUSH = 2'b10,
    MODE_HOLD  = 2'b11
  } mode_e;

  // Counter must represent 0..length inclusive.
  function automatic int cnt_width(input int length);
    return $clog2(length + 1);
  endfunction

endpackage

// File: rtl/tap_delay_line_ctrl_if.sv
// Request/response bundle of the delay line: master drives the update request,
// slave (the delay line) returns tap contents, enables and fill status.
interface tap_delay_line_ctrl_if
  import tap_delay_line_ctrl_pkg::*;
#(
  parameter int LENGTH = 16,
  parameter int WIDTH  = 8,
  parameter int CNT_W  = cnt_width(LENGTH)
);

  logic                    in_valid;
  logic [1:0]              mode;
  logic [WIDTH-1:0]        in_sample;
  logic [LENGTH*WIDTH-1:0] load_vec;
  logic [LENGTH-1:0]       freeze_mask;
  logic [LENGTH*WIDTH-1:0] taps_out;
  logic [LENGTH-1:0]       tap_en;
  logic [CNT_W-1:0]        fill_cnt;
  logic                    full;
  logic                    out_valid;

  modport master (
    output in_valid, mode, in_sample, load_vec, freeze_mask,
    input  taps_out, tap_en, fill_cnt, full, out_valid
  );

  modport slave (
    input  in_valid, mode, in_sample, load_vec, freeze_mask,
    output taps_out, tap_en, fill_cnt, full, out_valid
  );

endinterface

// File: rtl/tap_delay_line_ctrl_delay.sv
// Enabled N-stage delay of a WIDTH-bit sample; one stage per enabled clock.
// Latency N enabled cycles; holds all stages while i_en is low.
module DelayNUnit_en #(
  parameter int WIDTH = 8,
  parameter int N     = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_dat,
  output logic [WIDTH-1:0] o_dat
);

  logic [WIDTH-1:0] r_pipe [N];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) r_pipe[i] <= '0;
    end else if (i_en) begin
      r_pipe[0] <= i_dat;
      for (int i = 1; i < N; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_dat = r_pipe[N-1];

endmodule

// File: rtl/tap_delay_line_ctrl.sv
// Tapped delay line holding the filter regressor: shift, load, flush or hold.
// Latency 1 cycle, accepts every cycle; fill counter, full and out_valid strobe.
module tap_delay_line_ctrl
  import tap_delay_line_ctrl_pkg::*;
#(
  parameter int LENGTH = 16,
  parameter int WIDTH  = 8,
  parameter int CNT_W  = cnt_width(LENGTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  tap_delay_line_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LENGTH);

  logic                    w_accept;
  logic [LENGTH-1:0]       w_tap_en;
  logic [WIDTH-1:0]        w_shift_src [LENGTH];
  logic [WIDTH-1:0]        w_tap_d     [LENGTH];
  logic [WIDTH-1:0]        w_tap_q     [LENGTH];
  logic [LENGTH*WIDTH-1:0] w_taps_out;
  logic [CNT_W-1:0]        w_fill_nxt;
  logic [CNT_W-1:0]        r_fill_cnt;
  logic                    r_full;
  logic                    r_out_valid;

  assign w_accept = bus.in_valid && (bus.mode != MODE_HOLD);

  // Flush clears every tap regardless of the freeze mask.
  always_comb begin
    w_tap_en = '0;
    if (w_accept) begin
      if (bus.mode == MODE_FLUSH) w_tap_en = '1;
      else                        w_tap_en = ~bus.freeze_mask;
    end
  end

  genvar k;
  for (k = 0; k < LENGTH; k++) begin : g_tap
    if (k == 0) begin : g_head
      assign w_shift_src[k] = bus.in_sample;
    end else begin : g_body
      // Feed from the neighbour's register even when that neighbour is frozen.
      assign w_shift_src[k] = w_tap_q[k-1];
    end

    always_comb begin
      w_tap_d[k] = '0;
      case (mode_e'(bus.mode))
        MODE_SHIFT: w_tap_d[k] = w_shift_src[k];
        MODE_LOAD:  w_tap_d[k] = bus.load_vec[WIDTH*k +: WIDTH];
        default:    w_tap_d[k] = '0;
      endcase
    end

    DelayNUnit_en #(
      .WIDTH (WIDTH),
      .N     (1)
    ) u_tap (
      .clk   (clk),
      .reset (reset),
      .i_en  (w_tap_en[k]),
      .i_dat (w_tap_d[k]),
      .o_dat (w_tap_q[k])
    );
  end

  always_comb begin
    w_taps_out = '0;
    for (int i = 0; i < LENGTH; i++) w_taps_out[WIDTH*i +: WIDTH] = w_tap_q[i];
  end

  always_comb begin
    w_fill_nxt = r_fill_cnt;
    if (w_accept) begin
      case (mode_e'(bus.mode))
        MODE_SHIFT: w_fill_nxt = (r_fill_cnt == FULL_CNT) ? FULL_CNT : r_fill_cnt + 1'b1;
        MODE_LOAD:  w_fill_nxt = FULL_CNT;
        MODE_FLUSH: w_fill_nxt = '0;
        default:    w_fill_nxt = r_fill_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fill_cnt  <= '0;
      r_full      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_fill_cnt  <= w_fill_nxt;
      r_full      <= (w_fill_nxt == FULL_CNT);
      r_out_valid <= w_accept;
    end
  end

  assign bus.taps_out  = w_taps_out;
  assign bus.tap_en    = w_tap_en;
  assign bus.fill_cnt  = r_fill_cnt;
  assign bus.full      = r_full;
  assign bus.out_valid = r_out_valid;

endmodule
